icache_refill: RTL and testbench

Miss-refill controller directly upstream of the instruction cache. On a cache miss it wins the memory arbiter, reads the 16-byte line from byte-wide RAM one byte per cycle, and assembles the line. It then delivers the line to the cache as a one-cycle valid pulse with block address and 128-bit data. It is the sole producer of the cache's fill interface.

---
 rtl/icache_pkg.sv | 19 +
 rtl/refill_line_buffer.sv | 48 ++++
 rtl/icache_refill.sv | 233 +++++++++++++++++++++++
 tb/tb_icache_refill.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared constants and types for the instruction-cache miss refill path.
package icache_pkg;

    localparam int BLOCK_WIDTH = 4;
    localparam int BLOCK_SIZE  = 2 ** BLOCK_WIDTH;
    localparam int LINE_BITS   = BLOCK_SIZE * 8;
    localparam int CNT_WIDTH   = BLOCK_WIDTH + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_FETCH  = 3'd2,
        ST_DONE   = 3'd3,
        ST_SETTLE = 3'd4
    } refill_state_t;

    typedef logic [LINE_BITS-1:0] line_t;

endpackage

// File: rtl/refill_line_buffer.sv
// Line assembly register: one byte written per enabled cycle, cleared when a refill starts.
// line_next_o exposes the value the register takes at the next edge so the final byte can be forwarded.
module refill_line_buffer
    import icache_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   en_i,
    input  logic                   clear_i,
    input  logic                   wr_en_i,
    input  logic [BLOCK_WIDTH-1:0] wr_idx_i,
    input  logic [7:0]             wr_byte_i,
    output logic [LINE_BITS-1:0]   line_o,
    output logic [LINE_BITS-1:0]   line_next_o
);

    line_t line_q;
    line_t line_d;

    // Next line value: clear on start, otherwise drop the byte into its lane.
    always_comb begin
        line_d = line_q;
        if (en_i) begin
            if (clear_i) begin
                line_d = '0;
            end else if (wr_en_i) begin
                line_d[{wr_idx_i, 3'b000} +: 8] = wr_byte_i;
            end else begin
                line_d = line_q;
            end
        end else begin
            line_d = line_q;
        end
    end

    // Line storage register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign line_o      = line_q;
    assign line_next_o = line_d;

endmodule

// File: rtl/icache_refill.sv
// Instruction-cache miss refill controller: arbitrates for RAM, streams a 16-byte line in byte by byte
// and delivers it as a single fill pulse. Define ICACHE_PREFETCH_EN to add a next-line prefetch.
module icache_refill
    import icache_pkg::*;
(
    input  logic                   clkIn,
    input  logic                   resetIn,
    input  logic                   readyIn,
    input  logic                   flushIn,
    input  logic                   missIn,
    input  logic [31:BLOCK_WIDTH]  missAddrIn,
    output logic                   reqOut,
    input  logic                   grantIn,
    output logic [31:0]            ramAddrOut,
    input  logic [7:0]             ramDataIn,
    output logic                   memDataValid,
    output logic [31:BLOCK_WIDTH]  memAddr,
    output logic [LINE_BITS-1:0]   memDataIn
);

    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(BLOCK_SIZE);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    refill_state_t          state_q, state_d;
    logic [31:BLOCK_WIDTH]  blk_addr_q, blk_addr_d;
    logic [CNT_WIDTH-1:0]   iss_q, iss_d;
    logic [CNT_WIDTH-1:0]   rcv_q, rcv_d;
    logic                   req_q, req_d;
    logic [31:0]            ram_addr_q, ram_addr_d;
    logic                   mem_valid_q, mem_valid_d;
    logic [31:BLOCK_WIDTH]  mem_addr_q, mem_addr_d;
    line_t                  mem_data_q, mem_data_d;
    logic                   held_q, held_d;
    logic [7:0]             hold_byte_q, hold_byte_d;
`ifdef ICACHE_PREFETCH_EN
    logic                   prefetch_q, prefetch_d;
`endif

    logic                   capture_s;
    logic                   buf_clear_s;
    logic                   buf_wr_s;
    logic [7:0]             buf_byte_s;
    line_t                  line_s;
    line_t                  line_next_s;

    refill_line_buffer u_line_buf (
        .clk_i       (clkIn),
        .rst_n_i     (resetIn),
        .en_i        (readyIn),
        .clear_i     (buf_clear_s),
        .wr_en_i     (buf_wr_s),
        .wr_idx_i    (rcv_q[BLOCK_WIDTH-1:0]),
        .wr_byte_i   (buf_byte_s),
        .line_o      (line_s),
        .line_next_o (line_next_s)
    );

    // Refill FSM, counters and output next-state.
    always_comb begin
        state_d     = state_q;
        blk_addr_d  = blk_addr_q;
        iss_d       = iss_q;
        rcv_d       = rcv_q;
        req_d       = req_q;
        ram_addr_d  = ram_addr_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        held_d      = held_q;
        hold_byte_d = hold_byte_q;
`ifdef ICACHE_PREFETCH_EN
        prefetch_d  = prefetch_q;
`endif
        buf_clear_s = 1'b0;
        buf_wr_s    = 1'b0;
        buf_byte_s  = held_q ? hold_byte_q : ramDataIn;
        capture_s   = (state_q == ST_FETCH) && (iss_q > rcv_q);

        if (readyIn) begin
            held_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (missIn && !flushIn) begin
                        blk_addr_d = missAddrIn;
                        req_d      = 1'b1;
                        state_d    = ST_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (flushIn) begin
                        req_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else if (grantIn) begin
                        iss_d       = '0;
                        rcv_d       = '0;
                        buf_clear_s = 1'b1;
                        state_d     = ST_FETCH;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_FETCH: begin
                    if (flushIn) begin
                        req_d   = 1'b0;
                        iss_d   = '0;
                        rcv_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        if (iss_q < CNT_FULL) begin
                            iss_d = iss_q + CNT_ONE;
                        end else begin
`ifdef ICACHE_PREFETCH_EN
                            // A demand refill keeps the grant so the prefetch needs no re-arbitration.
                            req_d = !prefetch_q;
`else
                            req_d = 1'b0;
`endif
                        end
                        if (capture_s) begin
                            buf_wr_s = 1'b1;
                            rcv_d    = rcv_q + CNT_ONE;
                        end else begin
                            rcv_d = rcv_q;
                        end
                        if (rcv_d == CNT_FULL) begin
                            mem_addr_d = blk_addr_q;
                            mem_data_d = line_next_s;
                            state_d    = ST_DONE;
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
`ifdef ICACHE_PREFETCH_EN
                    if (!prefetch_q && !flushIn) begin
                        blk_addr_d  = blk_addr_q + (32-BLOCK_WIDTH)'(1);
                        iss_d       = '0;
                        rcv_d       = '0;
                        buf_clear_s = 1'b1;
                        prefetch_d  = 1'b1;
                        state_d     = ST_FETCH;
                    end else begin
                        req_d   = 1'b0;
                        state_d = ST_SETTLE;
                    end
`else
                    state_d = ST_SETTLE;
`endif
                end
                ST_SETTLE: begin
                    // Skipping a cycle lets the cache drop its now-stale miss.
                    state_d = ST_IDLE;
                end
                default: begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase

            if ((state_d == ST_FETCH) && (iss_d < CNT_FULL)) begin
                ram_addr_d = {blk_addr_d, iss_d[BLOCK_WIDTH-1:0]};
            end else begin
                ram_addr_d = ram_addr_q;
            end
            mem_valid_d = (state_d == ST_DONE);
`ifdef ICACHE_PREFETCH_EN
            if ((state_d != ST_FETCH) && (state_d != ST_DONE)) begin
                prefetch_d = 1'b0;
            end else begin
                prefetch_d = prefetch_d;
            end
`endif
        end else begin
            // The RAM byte due in a frozen cycle is parked until the next enabled cycle.
            if (capture_s && !held_q) begin
                held_d      = 1'b1;
                hold_byte_d = ramDataIn;
            end else begin
                held_d = held_q;
            end
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            state_q     <= ST_IDLE;
            blk_addr_q  <= '0;
            iss_q       <= '0;
            rcv_q       <= '0;
            req_q       <= 1'b0;
            ram_addr_q  <= '0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            held_q      <= 1'b0;
            hold_byte_q <= '0;
        end else begin
            state_q     <= state_d;
            blk_addr_q  <= blk_addr_d;
            iss_q       <= iss_d;
            rcv_q       <= rcv_d;
            req_q       <= req_d;
            ram_addr_q  <= ram_addr_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            held_q      <= held_d;
            hold_byte_q <= hold_byte_d;
        end
    end

`ifdef ICACHE_PREFETCH_EN
    // Marks the refill in flight as the speculative next line.
    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            prefetch_q <= 1'b0;
        end else begin
            prefetch_q <= prefetch_d;
        end
    end
`endif

    assign reqOut       = req_q;
    assign ramAddrOut   = ram_addr_q;
    assign memDataValid = mem_valid_q;
    assign memAddr      = mem_addr_q;
    assign memDataIn    = mem_data_q;

endmodule

// File: tb/tb_icache_refill.sv
// Self-checking bench for icache_refill: directed table, hand sequences and randomized refills
// against a line model built from a byte-addressed RAM function.
module tb_icache_refill;
    import icache_pkg::*;

    logic                  clkIn = 1'b0;
    logic                  resetIn = 1'b1;
    logic                  readyIn = 1'b1;
    logic                  flushIn = 1'b0;
    logic                  missIn = 1'b0;
    logic [31:BLOCK_WIDTH] missAddrIn = '0;
    logic                  reqOut;
    logic                  grantIn = 1'b0;
    logic [31:0]           ramAddrOut;
    logic [7:0]            ramDataIn = 8'h00;
    logic                  memDataValid;
    logic [31:BLOCK_WIDTH] memAddr;
    logic [LINE_BITS-1:0]  memDataIn;

    int          n_checks = 0;
    int          n_pass = 0;
    int          grant_viol = 0;
    logic        granted_r = 1'b0;
    logic [7:0]  ram_seed = 8'h00;

    typedef struct {
        logic [31:BLOCK_WIDTH] addr;
        int                    gdly;
        int                    frz_k;
        int                    frz_len;
        int                    flush_k;
        bit                    hold_miss;
        logic [7:0]            seed;
        bit                    exp_fill;
        int                    exp_lat;
    } case_t;

    case_t tbl[9];

    always #5 clkIn = ~clkIn;

    icache_refill dut (
        .clkIn        (clkIn),
        .resetIn      (resetIn),
        .readyIn      (readyIn),
        .flushIn      (flushIn),
        .missIn       (missIn),
        .missAddrIn   (missAddrIn),
        .reqOut       (reqOut),
        .grantIn      (grantIn),
        .ramAddrOut   (ramAddrOut),
        .ramDataIn    (ramDataIn),
        .memDataValid (memDataValid),
        .memAddr      (memAddr),
        .memDataIn    (memDataIn)
    );

    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        logic [31:0] h;
        if (ram_seed == 8'h00) return 8'h10 + {4'h0, a[3:0]};
        h = a * 32'h9E3779B1;
        return h[31:24] ^ ram_seed;
    endfunction

    function automatic logic [LINE_BITS-1:0] model_line(input logic [31:BLOCK_WIDTH] blk);
        logic [LINE_BITS-1:0] l;
        l = '0;
        for (int k = 0; k < BLOCK_SIZE; k++) l[k*8 +: 8] = ram_byte({blk, 4'(k)});
        return l;
    endfunction

    // Byte-wide synchronous RAM: data for an address appears one cycle after it is presented.
    always @(posedge clkIn) ramDataIn <= ram_byte(ramAddrOut);

    // Grant must stay high for as long as reqOut does once granted.
    always @(posedge clkIn) begin
        if (resetIn && granted_r && reqOut && !grantIn) grant_viol <= grant_viol + 1;
        if (!resetIn || !reqOut) granted_r <= 1'b0;
        else if (grantIn) granted_r <= 1'b1;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic run_case(input case_t c);
        int                    n_pulse;
        int                    p_abs[2];
        logic [31:BLOCK_WIDTH] p_addr[2];
        logic [LINE_BITS-1:0]  p_data[2];
        int                    exp_n;
        int                    final_done;
        int                    limit;
        logic [31:0]           frz_addr;
        logic [31:BLOCK_WIDTH] exp_addr;
        n_pulse = 0;
        frz_addr = '0;
        ram_seed = c.seed;
        exp_n = c.exp_fill ? 1 : 0;
`ifdef ICACHE_PREFETCH_EN
        if (c.exp_fill && c.flush_k != 17) exp_n = 2;
`endif
        final_done = (exp_n == 2) ? c.exp_lat + 18 : c.exp_lat;
        limit = (exp_n == 0) ? 24 : final_done + 4;

        @(negedge clkIn);
        missIn = 1'b1; missAddrIn = c.addr; flushIn = 1'b0; readyIn = 1'b1;
        @(negedge clkIn);
        if (!c.hold_miss) missIn = 1'b0;
        missAddrIn = c.addr ^ 28'h5A5A5A5;
        check("req_rise", reqOut, 1'b1);
        for (int i = 0; i < c.gdly; i++) @(negedge clkIn);
        grantIn = 1'b1;

        for (int t = 0; t <= limit; t++) begin
            @(negedge clkIn);
            if (!reqOut) grantIn = 1'b0;
            if (memDataValid) begin
                if (n_pulse < 2) begin
                    p_abs[n_pulse] = t; p_addr[n_pulse] = memAddr; p_data[n_pulse] = memDataIn;
                end
                n_pulse++;
            end
            if (t == 0) check("ram_addr_first", ramAddrOut, {c.addr, 4'h0});
            if (t == 15 && c.frz_len == 0 && c.flush_k > 15) check("ram_addr_last", ramAddrOut, {c.addr, 4'hF});
            if (c.frz_len > 0 && t == c.frz_k) begin
                readyIn = 1'b0; frz_addr = ramAddrOut;
            end
            if (c.frz_len > 0 && t == c.frz_k + c.frz_len) begin
                readyIn = 1'b1;
                check("freeze_hold", ramAddrOut, frz_addr);
            end
            if (t == c.flush_k) flushIn = 1'b1;
            if (t == c.flush_k + 1) begin
                flushIn = 1'b0;
                if (c.flush_k <= 16) check("flush_req_drop", reqOut, 1'b0);
            end
            if (exp_n == 2 && (t == c.exp_lat || t == c.exp_lat + 1)) check("pf_req_held", reqOut, 1'b1);
            if (exp_n > 0 && t == final_done + 1) missIn = 1'b0;
            if (exp_n > 0 && t == final_done + 2) check("settle_no_req", reqOut, 1'b0);
        end

        check("fill_count", n_pulse, exp_n);
        for (int i = 0; i < exp_n && i < n_pulse && i < 2; i++) begin
            exp_addr = (i == 0) ? c.addr : c.addr + 28'd1;
            check("fill_latency", p_abs[i], (i == 0) ? c.exp_lat : c.exp_lat + 18);
            check("fill_addr", p_addr[i], exp_addr);
            check("fill_data", p_data[i], model_line(exp_addr));
        end
        check("idle_end", reqOut, 1'b0);
        missIn = 1'b0; flushIn = 1'b0; readyIn = 1'b1; grantIn = 1'b0;
    endtask

    initial begin
        case_t rc;
        int    mode;
        int    pulses;

        //           addr          gdly frz_k len flush hold seed   fill lat
        tbl[0] = '{28'h0000100,   2,   99,   0,  99,   0, 8'h00, 1, 17};
        tbl[1] = '{28'h0000100,   0,    6,   3,  99,   0, 8'h00, 1, 20};
        tbl[2] = '{28'h0000300,   1,   99,   0,   9,   0, 8'h00, 0, 17};
        tbl[3] = '{28'h0000200,   0,   99,   0,  99,   0, 8'h00, 1, 17};
        tbl[4] = '{28'h0000400,   0,   99,   0,  99,   1, 8'h3C, 1, 17};
        tbl[5] = '{28'hFFFFFFF,   1,   99,   0,  17,   0, 8'h77, 1, 17};
        tbl[6] = '{28'hFFFFFFF,   0,   99,   0,  99,   0, 8'h00, 1, 17};
        tbl[7] = '{28'h0ABCDEF,   3,   16,   2,  99,   0, 8'h5A, 1, 19};
        tbl[8] = '{28'h0001230,   0,   99,   0,   0,   0, 8'h00, 0, 17};

        #1 resetIn = 1'b0;
        #2;
        check("rst_req", reqOut, 1'b0);
        check("rst_valid", memDataValid, 1'b0);
        check("rst_ram_addr", ramAddrOut, 32'h0);
        check("rst_mem_addr", memAddr, 28'h0);
        check("rst_mem_data", memDataIn, 128'h0);
        @(negedge clkIn);
        resetIn = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_case(tbl[i]);
            if (i == 0) check("line_const", memDataIn, 128'h1F1E1D1C1B1A19181716151413121110);
        end

        // Flush and miss in the same idle cycle: no request.
        @(negedge clkIn);
        missIn = 1'b1; flushIn = 1'b1; missAddrIn = 28'h0000700;
        @(negedge clkIn);
        check("flush_wins", reqOut, 1'b0);
        missIn = 1'b0; flushIn = 1'b0;
        @(negedge clkIn);
        check("flush_wins_after", reqOut, 1'b0);

        // Asynchronous reset while fetching byte 7.
        ram_seed = 8'h00;
        @(negedge clkIn);
        missIn = 1'b1; missAddrIn = 28'h0000500;
        @(negedge clkIn);
        missIn = 1'b0; grantIn = 1'b1;
        repeat (8) @(negedge clkIn);
        check("pre_rst_req", reqOut, 1'b1);
        #2 resetIn = 1'b0;
        #1;
        check("async_rst_req", reqOut, 1'b0);
        check("async_rst_valid", memDataValid, 1'b0);
        check("async_rst_mem_addr", memAddr, 28'h0);
        check("async_rst_mem_data", memDataIn, 128'h0);
        grantIn = 1'b0;
        @(negedge clkIn);
        resetIn = 1'b1;
        pulses = 0;
        repeat (25) begin
            @(negedge clkIn);
            if (memDataValid) pulses++;
        end
        check("post_rst_no_fill", pulses, 0);
        check("post_rst_idle", reqOut, 1'b0);

        // Randomized refills checked against the line model.
        for (int n = 0; n < 12; n++) begin
            rc.addr = 28'($urandom);
            rc.gdly = int'($urandom_range(0, 3));
            rc.frz_k = 99; rc.frz_len = 0; rc.flush_k = 99; rc.hold_miss = 1'b0;
            rc.seed = 8'($urandom_range(1, 255));
            mode = int'($urandom_range(0, 2));
            if (mode == 1) begin
                rc.frz_k = int'($urandom_range(1, 16));
                rc.frz_len = int'($urandom_range(1, 4));
            end else if (mode == 2) begin
                rc.flush_k = int'($urandom_range(0, 17));
            end else begin
                rc.hold_miss = ($urandom_range(0, 1) == 1);
            end
            rc.exp_fill = !(rc.flush_k <= 16);
            rc.exp_lat = 17 + rc.frz_len;
            run_case(rc);
        end

        check("grant_hold", grant_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
